// File: rtl/scan_pkg.sv
// Shared types, sizes and channel-ordering helpers for the scan sequencer.
package scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DWELL
    } state_t;

    // Counter width able to hold the larger of the two interval lengths.
    function automatic int cnt_width(input int dwell, input int blank);
        int longest;
        longest = (dwell > blank) ? dwell : blank;
        return $clog2(longest + 1);
    endfunction

    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] cur);
        return cur + 1'b1;
    endfunction

    // Nearest set mask bit after cur, wrapping; falls back to cur itself.
    function automatic logic [SEL_W-1:0] next_ch_masked(input logic [SEL_W-1:0] cur,
                                                        input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] res;
        logic [SEL_W-1:0] idx;
        res = cur;
        for (int i = NUM_CH - 1; i >= 1; i--) begin
            idx = cur + SEL_W'(i);
            if (mask[idx]) res = idx;
        end
        return res;
    endfunction

    function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) res = SEL_W'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter shared by the blanking and dwell intervals;
// tc is high while the count sits at zero.
module scan_timer
    import scan_pkg::*;
#(
    parameter int DWELL = 1000,
    parameter int BLANK = 10,
    parameter int W     = cnt_width(DWELL, BLANK)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed channel scanner driving a 2-to-4 decoder's select/enable.
// Optional per-channel masking is built when SCAN_MASK_EN is defined.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL = 1000,
    parameter int BLANK = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
`ifdef SCAN_MASK_EN
    input  logic [NUM_CH-1:0] ch_mask,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             enable,
    output logic             frame_done
);

    localparam int              CNT_W     = cnt_width(DWELL, BLANK);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;
    localparam bit              HAS_BLANK = (BLANK > 0);

    state_t           state_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             enable_reg;
    logic             frame_done_reg;

    logic             tc;
    logic             load;
    logic [CNT_W-1:0] load_val;

    logic             mask_ok;
    logic             cur_ok;
    logic [SEL_W-1:0] sel_adv;
    logic [SEL_W-1:0] sel_first;
    logic             skip_blank;

`ifdef SCAN_MASK_EN
    always_comb begin
        mask_ok   = |ch_mask;
        cur_ok    = ch_mask[sel_reg];
        sel_adv   = next_ch_masked(sel_reg, ch_mask);
        sel_first = first_ch(ch_mask);
    end
`else
    assign mask_ok   = 1'b1;
    assign cur_ok    = 1'b1;
    assign sel_adv   = next_ch(sel_reg);
    assign sel_first = '0;
`endif

    // With no blanking the dwell chains straight into the next dwell,
    // unless an empty mask forces the block to park in BLANK.
    assign skip_blank = !HAS_BLANK && mask_ok;

    always_comb begin
        load     = 1'b0;
        load_val = DWELL_LD;
        if (run) begin
            case (state_reg)
                ST_IDLE: begin
                    load     = 1'b1;
                    load_val = skip_blank ? DWELL_LD : BLANK_LD;
                end
                ST_BLANK: begin
                    if (tc && mask_ok && cur_ok) load = 1'b1;
                end
                ST_DWELL: begin
                    if (tc) begin
                        load     = 1'b1;
                        load_val = skip_blank ? DWELL_LD : BLANK_LD;
                    end
                end
                default: ;
            endcase
        end
    end

    scan_timer #(
        .DWELL (DWELL),
        .BLANK (BLANK),
        .W     (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= '0;
            enable_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (!run) begin
                state_reg  <= ST_IDLE;
                enable_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        sel_reg <= sel_first;
                        if (skip_blank) begin
                            state_reg  <= ST_DWELL;
                            enable_reg <= 1'b1;
                        end else begin
                            state_reg  <= ST_BLANK;
                            enable_reg <= 1'b0;
                        end
                    end
                    ST_BLANK: begin
                        // A mask edited during the gap may have dropped the
                        // current channel; hop to a live one before dwelling.
                        if (tc && mask_ok) begin
                            if (cur_ok) begin
                                state_reg  <= ST_DWELL;
                                enable_reg <= 1'b1;
                            end else begin
                                sel_reg <= sel_adv;
                            end
                        end
                    end
                    ST_DWELL: begin
                        if (tc) begin
                            sel_reg        <= sel_adv;
                            frame_done_reg <= mask_ok && (sel_adv <= sel_reg);
                            if (!skip_blank) begin
                                state_reg  <= ST_BLANK;
                                enable_reg <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= ST_IDLE;
                        enable_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel        = sel_reg;
    assign enable     = enable_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench: two scanners (BLANK=2 and BLANK=0, DWELL=4); every output
// change is matched against an expected {cycle, sel, enable, frame_done} queue.
module tb_scan_sequencer;
    import scan_pkg::*;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int FAR = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] ch_mask = 4'b0000;

    logic [1:0] sel_b2, sel_b0;
    logic       en_b2, en_b0, fd_b2, fd_b0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL(DW), .BLANK(BL)) u_b2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
`ifdef SCAN_MASK_EN
        .ch_mask    (ch_mask),
`endif
        .sel        (sel_b2),
        .enable     (en_b2),
        .frame_done (fd_b2)
    );

    scan_sequencer #(.DWELL(DW), .BLANK(0)) u_b0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
`ifdef SCAN_MASK_EN
        .ch_mask    (ch_mask),
`endif
        .sel        (sel_b0),
        .enable     (en_b0),
        .frame_done (fd_b0)
    );

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    ev_t        exp_q [2][$];
    logic [3:0] last_v [2];
    logic [3:0] prev_v [2];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] cur_val(input int d);
        return (d == 0) ? {sel_b2, en_b2, fd_b2} : {sel_b0, en_b0, fd_b0};
    endfunction

    // Monitor: any change of {sel,enable,frame_done} is one transaction.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [3:0] v;
            ev_t        e;
            v = cur_val(d);
            if (mon_en && v != prev_v[d]) begin
                n_checks++;
                if (exp_q[d].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change dut%0d: got cyc %0d sel=%0d en=%0d fd=%0d, required no change",
                             d, cyc, v[3:2], v[1], v[0]);
                end else begin
                    e = exp_q[d].pop_front();
                    if (e.cyc != cyc || e.val != v) begin
                        n_fail++;
                        $display("FAIL event dut%0d: got cyc %0d sel=%0d en=%0d fd=%0d, required cyc %0d sel=%0d en=%0d fd=%0d",
                                 d, cyc, v[3:2], v[1], v[0], e.cyc, e.val[3:2], e.val[1], e.val[0]);
                    end else begin
                        $display("dut%0d cyc %0d sel=%0d en=%0d fd=%0d ok", d, cyc, v[3:2], v[1], v[0]);
                    end
                end
            end
            prev_v[d] = v;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end else begin
            $display("%s = %0d ok", name, got);
        end
    endtask

    // Queue an expected output value at cycle c, skipping non-changes.
    task automatic add(input int d, input int c, input int ts, input logic [3:0] v);
        ev_t x;
        if (c < ts && v != last_v[d]) begin
            x.cyc = c;
            x.val = v;
            exp_q[d].push_back(x);
            last_v[d] = v;
        end
    endtask

    // Expected events for an unmasked scan started at edge t0 and stopped at t_stop.
    task automatic gen_scan(input int d, input int b, input int t0, input int t_stop,
                            input logic [1:0] prev_sel, input bit add_stop);
        logic [1:0] ch;
        logic [1:0] nx;
        logic       on_in_gap;
        int         p;
        int         e;
        last_v[d] = {prev_sel, 2'b00};
        on_in_gap = (b == 0);
        add(d, t0, t_stop, {2'd0, on_in_gap, 1'b0});
        for (int k = 0; t0 + k * (DW + b) < t_stop; k++) begin
            ch = 2'(k % 4);
            nx = ch + 2'd1;
            p  = t0 + k * (DW + b);
            e  = p + b + DW;
            if (b > 0) add(d, p + b, t_stop, {ch, 1'b1, 1'b0});
            add(d, e, t_stop, {nx, on_in_gap, ch == 2'd3});
            if (ch == 2'd3) add(d, e + 1, t_stop, {nx, on_in_gap, 1'b0});
        end
        if (add_stop) add(d, t_stop, t_stop + 1, {last_v[d][3:2], 2'b00});
    endtask

    initial begin
        int t;
        int m;

        repeat (3) tick();
        check("reset_b2", int'(cur_val(0)), 0);
        check("reset_b0", int'(cur_val(1)), 0);
        rst_n = 1'b1;
        tick();
        check("idle_b2", int'(cur_val(0)), 0);
        check("idle_b0", int'(cur_val(1)), 0);
        mon_en = 1'b1;

        // Two full frames, then stop mid-dwell on channel 2 of the third frame.
        t = cyc + 1;
        gen_scan(0, BL, t, t + 63, 2'd0, 1'b1);
        gen_scan(1, 0,  t, t + 63, 2'd0, 1'b1);
        run = 1'b1;
        go_to(t + 62);
        run = 1'b0;

        // Restart from the first channel, stop early in the second channel.
        go_to(t + 67);
        t = cyc + 1;
        gen_scan(0, BL, t, t + 9, 2'd2, 1'b1);
        gen_scan(1, 0,  t, t + 9, 2'd3, 1'b1);
        run = 1'b1;
        go_to(t + 8);
        run = 1'b0;

        // Asynchronous reset in the middle of a scan.
        go_to(t + 12);
        t = cyc + 1;
        gen_scan(0, BL, t, t + 10, 2'd1, 1'b0);
        gen_scan(1, 0,  t, t + 10, 2'd2, 1'b0);
        run = 1'b1;
        go_to(t + 10);
        check("pending_before_reset_b2", exp_q[0].size(), 0);
        check("pending_before_reset_b0", exp_q[1].size(), 0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_b2", int'(cur_val(0)), 0);
        check("async_reset_b0", int'(cur_val(1)), 0);
        run = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

`ifdef SCAN_MASK_EN
        // Mask 1010: channels 1 and 3 alternate, frame_done on each 3->1 wrap.
        ch_mask = 4'b1010;
        t = cyc + 1;
        last_v[0] = 4'b0000;
        last_v[1] = 4'b0000;
        add(0, t,      FAR, 4'b0100);
        add(0, t + 2,  FAR, 4'b0110);
        add(0, t + 6,  FAR, 4'b1100);
        add(0, t + 8,  FAR, 4'b1110);
        add(0, t + 12, FAR, 4'b0101);
        add(0, t + 13, FAR, 4'b0100);
        add(0, t + 14, FAR, 4'b0110);
        add(0, t + 15, FAR, 4'b0100);
        add(1, t,      FAR, 4'b0110);
        add(1, t + 4,  FAR, 4'b1110);
        add(1, t + 8,  FAR, 4'b0111);
        add(1, t + 9,  FAR, 4'b0110);
        add(1, t + 12, FAR, 4'b1110);
        add(1, t + 15, FAR, 4'b1100);
        run = 1'b1;
        go_to(t + 14);
        run = 1'b0;

        // Empty mask parks in BLANK; enabling channel 2 gives one 4-cycle dwell.
        go_to(t + 18);
        ch_mask = 4'b0000;
        t = cyc + 1;
        m = t + 5;
        add(0, t,     FAR, 4'b0000);
        add(0, m,     FAR, 4'b1000);
        add(0, m + 1, FAR, 4'b1010);
        add(0, m + 5, FAR, 4'b1001);
        add(0, m + 6, FAR, 4'b1000);
        add(1, t,     FAR, 4'b0000);
        add(1, m,     FAR, 4'b1000);
        add(1, m + 1, FAR, 4'b1010);
        add(1, m + 5, FAR, 4'b1011);
        add(1, m + 6, FAR, 4'b1010);
        add(1, m + 7, FAR, 4'b1000);
        run = 1'b1;
        go_to(m - 1);
        ch_mask = 4'b0100;
        go_to(m + 6);
        run = 1'b0;
`endif

        go_to(cyc + 4);
        check("pending_at_end_b2", exp_q[0].size(), 0);
        check("pending_at_end_b0", exp_q[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
